// File: rtl/hd_mask_decoder.sv
// Sequential field decoder: expands a {invert, length, start} code into a 32-bit run mask,
// generating STEP bits per cycle behind valid/ready handshakes on both sides.
module hd_mask_decoder #(
   parameter int STEP  = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy
);

   localparam int         NCHUNK = WIDTH / STEP;
   localparam logic [4:0] LAST_K = 5'(NCHUNK - 1);

   generate
      if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16 || STEP == 32)) begin : g_bad_step
         $error("hd_mask_decoder: STEP must be 1, 2, 4, 8, 16 or 32");
      end
      if (WIDTH != 32) begin : g_bad_width
         $error("hd_mask_decoder: WIDTH must be 32");
      end
   endgenerate

   // S_RESET keeps in_ready low for the cycle in which rst is still asserted.
   typedef enum logic [1:0] {S_RESET, S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state_reg, state_next;
   logic [4:0]       p_reg;
   logic [6:0]       end_reg;
   logic             inv_reg;
   logic [4:0]       k_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] in_run;

   logic [5:0] n_field;
   logic [5:0] n_eff;
   logic [6:0] run_sum;
   logic [6:0] run_end;
   logic       unused_bits;

   assign unused_bits = ^x[15:12];

   // Saturate the length first, then clip the 7-bit end so the run never wraps.
   assign n_field = x[10:5];
   assign n_eff   = (n_field > 6'd32) ? 6'd32 : n_field;
   assign run_sum = 7'(x[4:0]) + 7'(n_eff);
   assign run_end = (run_sum > 7'd32) ? 7'd32 : run_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_RESET;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_RESET: state_next = S_IDLE;
         S_IDLE:  if (in_valid) state_next = S_BUSY;
         S_BUSY:  if (k_reg == LAST_K) state_next = S_DONE;
         S_DONE:  if (out_ready) state_next = S_IDLE;
         default: state_next = S_RESET;
      endcase
   end

   assign in_ready  = (state_reg == S_IDLE);
   assign busy      = (state_reg == S_BUSY);
   assign out_valid = (state_reg == S_DONE);
   assign y         = acc_reg;

   // Only the bits of chunk k are rewritten; the rest of the accumulator holds.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         localparam logic [6:0] BIT_POS   = 7'(gi);
         localparam logic [4:0] CHUNK_IDX = 5'(gi / STEP);
         assign in_run[gi]   = (BIT_POS >= {2'b00, p_reg}) && (BIT_POS < end_reg);
         assign acc_next[gi] = (k_reg == CHUNK_IDX) ? (in_run[gi] ^ inv_reg) : acc_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         p_reg   <= '0;
         end_reg <= '0;
         inv_reg <= 1'b0;
         k_reg   <= '0;
         acc_reg <= '0;
      end else if (state_reg == S_IDLE && in_valid) begin
         p_reg   <= x[4:0];
         end_reg <= run_end;
         inv_reg <= x[11];
         k_reg   <= '0;
         acc_reg <= '0;
      end else if (state_reg == S_BUSY) begin
         acc_reg <= acc_next;
         k_reg   <= k_reg + 5'd1;
      end
   end

endmodule

// File: tb/tb_hd_mask_decoder.sv
// Bench for hd_mask_decoder: STEP=4, 1 and 32 instances share stimulus; table vectors,
// random codes against a reference model, and hand-written backpressure/reset sequences.
module tb_hd_mask_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] x;
   logic        out_ready;
   logic        in_ready  [3];
   logic        out_valid [3];
   logic [31:0] y         [3];
   logic        busy      [3];

   int total = 0;
   int bad   = 0;
   int lat_exp [3] = '{8, 32, 1};
   logic [31:0] exp_q [$];

   typedef struct {
      logic [15:0] code;
      logic [31:0] exp_y;
   } vec_t;

   vec_t vecs [11];

   always #5 clk = ~clk;

   hd_mask_decoder #(.STEP(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .x(x),
      .out_valid(out_valid[0]), .out_ready(out_ready), .y(y[0]), .busy(busy[0])
   );
   hd_mask_decoder #(.STEP(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .x(x),
      .out_valid(out_valid[1]), .out_ready(out_ready), .y(y[1]), .busy(busy[1])
   );
   hd_mask_decoder #(.STEP(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .x(x),
      .out_valid(out_valid[2]), .out_ready(out_ready), .y(y[2]), .busy(busy[2])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [15:0] c);
      int p, n;
      logic [31:0] r;
      p = int'(c[4:0]);
      n = int'(c[10:5]);
      if (n > 32) n = 32;
      for (int i = 0; i < 32; i++) r[i] = ((i >= p) && (i < p + n)) ^ c[11];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(in_ready[0] && in_ready[1] && in_ready[2]) && t < 100) begin
         tick();
         t++;
      end
      if (t >= 100) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_code(input logic [15:0] code, input logic [31:0] exp_y);
      int cnt = 0;
      int lat [3] = '{0, 0, 0};
      logic [31:0] e;
      wait_idle();
      x = code;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      x = 16'($urandom);
      exp_q.push_back(exp_y);
      while (!(out_valid[0] && out_valid[1] && out_valid[2]) && cnt < 60) begin
         tick();
         cnt++;
         if (cnt == 1) chk("busy_step4", 32'(busy[0]), 32'd1);
         for (int d = 0; d < 3; d++) if (out_valid[d] && lat[d] == 0) lat[d] = cnt;
      end
      for (int d = 0; d < 3; d++) chk($sformatf("latency_dut%0d", d), 32'(lat[d]), 32'(lat_exp[d]));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
      for (int d = 0; d < 3; d++) chk($sformatf("y_dut%0d_x%h", d, code), y[d], e);
      $display("txn x=%h y4=%h y1=%h y32=%h exp=%h lat=%0d/%0d/%0d",
               code, y[0], y[1], y[2], e, lat[0], lat[1], lat[2]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_drop", 32'(out_valid[0]), 32'd0);
      chk("in_ready_after_out", 32'(in_ready[0]), 32'd1);
   endtask

   initial begin
      logic [31:0] held;
      logic [15:0] rc;
      int seen;

      vecs[0]  = '{16'h0104, 32'h00000FF0};
      vecs[1]  = '{16'h015C, 32'hF0000000};
      vecs[2]  = '{16'h07E0, 32'hFFFFFFFF};
      vecs[3]  = '{16'h0908, 32'hFFFF00FF};
      vecs[4]  = '{16'h0005, 32'h00000000};
      vecs[5]  = '{16'h0800, 32'hFFFFFFFF};
      vecs[6]  = '{16'h003F, 32'h80000000};
      vecs[7]  = '{16'h0400, 32'hFFFFFFFF};
      vecs[8]  = '{16'hF104, 32'h00000FF0};
      vecs[9]  = '{16'h0430, 32'hFFFF0000};
      vecs[10] = '{16'h0FFF, 32'h7FFFFFFF};

      rst = 1'b1;
      in_valid = 1'b0;
      x = 16'h0;
      out_ready = 1'b0;
      repeat (3) tick();
      for (int d = 0; d < 3; d++) begin
         chk("rst_in_ready", 32'(in_ready[d]), 32'd0);
         chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
         chk("rst_y", y[d], 32'd0);
         chk("rst_busy", 32'(busy[d]), 32'd0);
      end
      rst = 1'b0;
      tick();
      chk("in_ready_after_rst", 32'(in_ready[0]), 32'd1);

      for (int i = 0; i < 11; i++) run_code(vecs[i].code, vecs[i].exp_y);
      for (int i = 0; i < 6; i++) begin
         rc = 16'($urandom);
         run_code(rc, model(rc));
      end

      // Backpressure: hold the result for 20 cycles while a stray code is offered.
      wait_idle();
      x = 16'h0104;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      seen = 0;
      while (!(out_valid[0] && out_valid[1] && out_valid[2]) && seen < 60) begin
         tick();
         seen++;
      end
      chk("bp_valid", 32'(out_valid[0]), 32'd1);
      held = y[0];
      chk("bp_first_y", held, 32'h00000FF0);
      for (int c = 0; c < 20; c++) begin
         if (c == 5) begin x = 16'h0400; in_valid = 1'b1; end
         if (c == 6) in_valid = 1'b0;
         tick();
         chk("bp_y_hold", y[0], held);
         chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
         chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      end
      // Output handshake with a simultaneous in_valid must not start a new code.
      x = 16'h0400;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk("bp_after_valid", 32'(out_valid[0]), 32'd0);
      chk("bp_after_busy", 32'(busy[0]), 32'd0);
      chk("bp_after_in_ready", 32'(in_ready[0]), 32'd1);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (out_valid[0] || busy[0]) seen++;
      end
      chk("bp_no_extra_txn", 32'(seen), 32'd0);
      $display("txn backpressure x=0104 y=%h", held);

      // Reset in the third BUSY cycle discards the run.
      wait_idle();
      x = 16'h0200;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("mid_busy", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk("mrst_in_ready", 32'(in_ready[d]), 32'd0);
         chk("mrst_out_valid", 32'(out_valid[d]), 32'd0);
         chk("mrst_y", y[d], 32'd0);
         chk("mrst_busy", 32'(busy[d]), 32'd0);
      end
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (out_valid[0] || out_valid[1] || out_valid[2]) seen++;
      end
      chk("mrst_no_result", 32'(seen), 32'd0);
      $display("txn reset_mid_busy x=0200 discarded");
      run_code(16'h0104, 32'h00000FF0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hd_mask_decoder.md
Name: hd_mask_decoder

Overview:
- Sequential decoder for the 32-bit bit-manipulation benchmark family. It expands a compact 16-bit field code (start position, run length, invert flag) back into a full 32-bit word.
- It is the inverse direction of the combinational 32-in/16-out position/count encoders in this benchmark set.
- Builds the word STEP bits per cycle behind valid/ready handshakes on input and output, so it can sit between a code producer and a word consumer in the hybrid FHE test flow.

Parameters:
STEP, 4, bits of the output word generated per BUSY cycle; legal values 1, 2, 4, 8, 16, 32 (elaboration error otherwise)
WIDTH, 32, output word width; fixed at 32 in this revision

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  code x is valid
in_ready  output  1  block can accept a code
x  input  16  code: x[4:0]=start position p, x[10:5]=run length n (0..63), x[11]=invert, x[15:12] ignored
out_valid  output  1  result y is valid
out_ready  input  1  consumer accepts y
y  output  32  decoded word
busy  output  1  high while in BUSY state

Behaviour:
- Synchronicity and reset: one clock (clk), synchronous active-high reset (rst).
- Reset values: in_ready=0, out_valid=0, y=0, busy=0. The FSM enters IDLE, and in_ready rises the cycle after rst deasserts.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch p, the effective length, and the invert flag; clear the accumulator and chunk counter k; go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle compute chunk k, i.e. bits [k*STEP +: STEP]. Bit i is set iff p <= i < p+n_eff, XOR invert. Write the chunk into the accumulator and increment k. When k reaches 32/STEP-1, the final chunk is written that same cycle and the FSM goes to DONE.
  - DONE: out_valid=1 and y=accumulator, held stable until out_valid&&out_ready. On handshake, go to IDLE with out_valid=0 the next cycle.
- Latency: in handshake edge to out_valid high is exactly 32/STEP cycles (STEP=4: 8 cycles; STEP=32: 1 cycle). Throughput is one code per 32/STEP+2 cycles with out_ready tied high.
- Run length and truncation:
  - Effective length n_eff = min(n, 32). Codes 33..63 saturate to 32.
  - The run never wraps: bits at index >= 32 are discarded, so the upper bound is min(p+n_eff, 32).
  - p+n_eff arithmetic is 7 bits wide to avoid overflow.
- Boundary codes:
  - n=0 gives y=0x00000000, or 0xFFFFFFFF when invert is set.
  - p=31, n=1 gives y=0x80000000.
  - p=0, n>=32 gives y=0xFFFFFFFF.
- Backpressure: while in DONE with out_ready=0, y and out_valid hold indefinitely and in_valid is ignored (in_ready=0). No input is buffered.
- Simultaneous events: in DONE, out handshake and a new in_valid in the same cycle do not overlap. The new code is accepted at the earliest in IDLE on the following cycle.
- Reset mid-operation: rst in BUSY or DONE discards the accumulator and the pending result. Outputs return to their reset values the next cycle and no out_valid pulse is produced.
- x[15:12] have no effect on any output.
- y is registered; no combinational path from inputs to outputs except none (in_ready, out_valid, busy are state decodes).

Test Plan:
- Basic run: p=4, n=8, inv=0 (x=0x0104), STEP=4 -> out_valid rises 8 cycles after the accept edge, y=0x00000FF0.
- Truncation and saturation: p=28, n=10 -> y=0xF0000000. Then p=0, n=63 -> y=0xFFFFFFFF.
- Invert and zero length: p=8, n=8, inv=1 -> y=0xFFFF00FF. Then p=5, n=0, inv=0 -> y=0x00000000.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> y stable; in_ready=0 throughout; a pulsed in_valid is ignored. Raise out_ready -> one transfer, then IDLE.
- Reset mid-BUSY: accept p=0, n=16, assert rst on BUSY cycle 3 -> next cycle in_ready=0, out_valid=0, y=0, busy=0. No result is emitted; the next code decodes correctly.
- Parameter sweep: repeat the basic run with STEP=1 and STEP=32 -> latency of 32 and 1 cycles respectively, and an identical y.
